register_file_2r1w: RTL and testbench
=====================================

# register_file_2r1w

Parametrised MIPS general-purpose register file with two read ports and one write port. It replaces the fixed 32-entry, 32-bit read multiplexing with a configurable depth and width. It adds hardwired register zero, same-cycle write-to-read bypass, and an optional registered-read mode for pipelined datapaths. It sits between the decode stage (read addresses from rs/rt) and the write-back stage (write address/data).

## Interface
- N, 32: data width in bits, ≥1
- DEPTH, 32: number of registers; power of two, ≥2
- ADDR_W, $clog2(DEPTH): address width; derived, never overridden
- ZERO_REG, 1: 1 = register 0 reads 0 and ignores writes
- BYPASS, 1: 1 = a read of the register being written returns Write_Data
- REG_READ, 0: 0 = combinational read; 1 = registered read, one-cycle latency
- clk  in  1  rising-edge clock; one clock domain
- reset  in  1  asynchronous, active-high reset
- Reg_Write  in  1  write enable
- Write_Register  in  ADDR_W  write address
- Write_Data  in  N  write data
- Read_Register_1  in  ADDR_W  port-1 read address
- Read_Register_2  in  ADDR_W  port-2 read address
- Read_Enable  in  1  read request; in REG_READ=1, the output registers load only when this is high
- Read_Data_1  out  N  port-1 data
- Read_Data_2  out  N  port-2 data
- Read_Valid  out  1  read data valid

## Operation
- Storage: DEPTH×N flops. A write occurs on the rising clk edge when Reg_Write=1 and reset=0.
- ZERO_REG=1: writes to address 0 are dropped. Reads of address 0 return 0 regardless of bypass.
- Read path per port: raw = mem[addr]. When BYPASS=1, Reg_Write=1, Write_Register==addr, and the address is not the hardwired zero register, the port selects Write_Data instead.
- REG_READ=0 mode:
  - Read_Data_x is the selected value, combinationally.
  - Read_Valid = Read_Enable.
- REG_READ=1 mode:
  - On each edge with Read_Enable=1, Read_Data_x captures the selected value, including any bypassed Write_Data.
  - With Read_Enable=0, Read_Data_x holds its value (supports a pipeline stall).
  - Read_Valid is a flop loaded with Read_Enable every cycle.
- BYPASS=0:
  - REG_READ=0: a same-cycle read of the written register returns the old value.
  - REG_READ=1: the captured value is also the old value.
- Both ports may carry the same address. Both then return identical data.
- No invalid addresses exist, because DEPTH is a power of two.

## Timing
- Reset, asynchronous, takes effect immediately: every mem entry = 0, Read_Data_1/2 registers = 0, Read_Valid flop = 0.
  - In REG_READ=0 mode, outputs follow the cleared memory, i.e. 0.
- A write asserted while reset is high is discarded.
- Reset releasing mid-stall: output registers are 0 until the first edge with Read_Enable=1.
- Write latency: data is visible through mem on the cycle after the edge, or in the same cycle via bypass.
- Read latency: 0 cycles when REG_READ=0; 1 cycle when REG_READ=1 (data and Read_Valid both appear after edge k+1 for a request in cycle k).
- Simultaneous write and read of the same address, REG_READ=1, BYPASS=1: the register captures the new data, and mem updates on the same edge.
- No internal state machine. The only sequential elements are the storage, the optional output registers, and the Read_Valid flop.

## Structure
- Package regfile_pkg holds:
  - localparams REGFILE_DEFAULT_N=32 and REGFILE_DEFAULT_DEPTH=32
  - constant ZERO_ADDR=0
  - typedef for the read-mode encoding (RD_COMB=0, RD_REG=1)
- Sub-module regfile_read_mux: parametrised DEPTH:1, N-bit selector taking a packed array input.
  - Instantiated once per read port.
  - Bypass and zero-register override logic sits outside the mux, in the top module.
- The top module contains the storage, the write decode, the bypass compare, and the generate branch on REG_READ.

## Test plan
- Reset with defaults, then read addresses 0..31 with Read_Enable=1 → all reads return 0, Read_Valid=1 (REG_READ=0).
- Write 0xDEADBEEF to reg 5, then next cycle read reg 5 on both ports → both ports 0xDEADBEEF.
- Write 0x12345678 to reg 0 with ZERO_REG=1 → reg 0 reads 0. Same write with ZERO_REG=0 → reg 0 reads 0x12345678.
- Bypass check, writing 0xA5A5A5A5 to reg 9 while reading reg 9 in the same cycle:
  - BYPASS=1 → 0xA5A5A5A5 appears that cycle.
  - BYPASS=0 → the prior value 0 appears, and 0xA5A5A5A5 appears the next cycle.
- REG_READ=1, N=16, DEPTH=8, Read_Enable pattern 1,0,0,1, with reg 3 = 0x00FF, then written to 0x0F0F in cycle 1:
  - Read_Valid follows 1,0,0,1 delayed by one cycle.
  - Data reads 0x00FF through the stall and 0x0F0F after the second request.
- Assert reset asynchronously mid-cycle after several writes → the outputs and Read_Valid go to 0 before the next edge. All registers read 0 after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read/1-write register file.
//   REGFILE_DEFAULT_N     : default data width
//   REGFILE_DEFAULT_DEPTH : default register count
//   ZERO_ADDR             : address of the hardwired zero register
//   read_mode_e           : combinational vs registered read path
package regfile_pkg;

  localparam int unsigned REGFILE_DEFAULT_N     = 32;
  localparam int unsigned REGFILE_DEFAULT_DEPTH = 32;
  localparam int unsigned ZERO_ADDR             = 0;

  typedef enum logic {
    RD_COMB = 1'b0,
    RD_REG  = 1'b1
  } read_mode_e;

endpackage

// File: rtl/regfile_read_mux.sv
// DEPTH:1 N-bit read selector over a packed register array.
//   data_i : packed array of all registers
//   sel_i  : register index
//   data_o : selected register contents
module regfile_read_mux #(
  parameter int unsigned N      = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][N-1:0] data_i,
  input  logic [ADDR_W-1:0]       sel_i,
  output logic [N-1:0]            data_o
);

  // DEPTH is a power of two, so every sel_i value is a valid index.
  assign data_o = data_i[sel_i];

endmodule

// File: rtl/register_file_2r1w.sv
// Parametrised general-purpose register file, two read ports, one write port.
//   clk, reset       : rising-edge clock, asynchronous active-high reset
//   Reg_Write        : write enable for Write_Register/Write_Data
//   Read_Register_x  : read addresses for ports 1 and 2
//   Read_Enable      : read request; gates output register loads when REG_READ=1
//   Read_Data_x      : read data (combinational or registered)
//   Read_Valid       : read data valid
// Options: ZERO_REG hardwires register 0 to zero, BYPASS forwards same-cycle
// write data to a matching read, REG_READ adds one cycle of read latency.
module register_file_2r1w
  import regfile_pkg::*;
#(
  parameter int unsigned N        = REGFILE_DEFAULT_N,
  parameter int unsigned DEPTH    = REGFILE_DEFAULT_DEPTH,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          REG_READ = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Reg_Write,
  input  logic [ADDR_W-1:0] Write_Register,
  input  logic [N-1:0]      Write_Data,
  input  logic [ADDR_W-1:0] Read_Register_1,
  input  logic [ADDR_W-1:0] Read_Register_2,
  input  logic              Read_Enable,
  output logic [N-1:0]      Read_Data_1,
  output logic [N-1:0]      Read_Data_2,
  output logic              Read_Valid
);

  localparam read_mode_e        ReadMode = read_mode_e'(REG_READ);
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_ADDR);

  logic [DEPTH-1:0][N-1:0] mem_q;
  logic                    wr_en;

  // Writes to the hardwired zero register are dropped so mem stays clean.
  assign wr_en = Reg_Write && !(ZERO_REG && (Write_Register == ZeroAddr));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
    end else if (wr_en) begin
      mem_q[Write_Register] <= Write_Data;
    end
  end

  logic [ADDR_W-1:0] rd_addr [2];
  logic [N-1:0]      rd_raw  [2];
  logic [N-1:0]      rd_sel  [2];

  assign rd_addr[0] = Read_Register_1;
  assign rd_addr[1] = Read_Register_2;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic is_zero;
    logic hit;

    regfile_read_mux #(
      .N      (N),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_mux (
      .data_i (mem_q),
      .sel_i  (rd_addr[p]),
      .data_o (rd_raw[p])
    );

    assign is_zero = ZERO_REG && (rd_addr[p] == ZeroAddr);
    assign hit     = BYPASS && Reg_Write && (Write_Register == rd_addr[p]) && !is_zero;
    // Zero override wins over bypass.
    assign rd_sel[p] = is_zero ? '0 : (hit ? Write_Data : rd_raw[p]);
  end

  if (ReadMode == RD_REG) begin : g_reg_read
    logic [N-1:0] rd1_q;
    logic [N-1:0] rd2_q;
    logic         valid_q;

    // Data holds while Read_Enable is low so a stalled stage keeps its operands.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd1_q   <= '0;
        rd2_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= Read_Enable;
        if (Read_Enable) begin
          rd1_q <= rd_sel[0];
          rd2_q <= rd_sel[1];
        end
      end
    end

    assign Read_Data_1 = rd1_q;
    assign Read_Data_2 = rd2_q;
    assign Read_Valid  = valid_q;
  end else begin : g_comb_read
    assign Read_Data_1 = rd_sel[0];
    assign Read_Data_2 = rd_sel[1];
    assign Read_Valid  = Read_Enable;
  end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Self-checking bench: four 32x32 configurations share one stimulus stream and
// are compared against a behavioural model; a 16-bit x 8 registered-read
// instance runs a directed stall sequence.
module tb_register_file_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        re;
  logic [31:0] rd1 [4];
  logic [31:0] rd2 [4];
  logic        rv  [4];

  logic        s_we;
  logic [2:0]  s_wa;
  logic [15:0] s_wd;
  logic [2:0]  s_ra1;
  logic [2:0]  s_ra2;
  logic        s_re;
  logic [15:0] s_rd1;
  logic [15:0] s_rd2;
  logic        s_rv;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Configurations: {zero_reg, bypass, reg_read}
  bit cfg_zero [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit cfg_byp  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit cfg_rr   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  register_file_2r1w #(.N(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1), .REG_READ(1'b0)) u_def (
    .clk(clk), .reset(reset), .Reg_Write(we), .Write_Register(wa), .Write_Data(wd),
    .Read_Register_1(ra1), .Read_Register_2(ra2), .Read_Enable(re),
    .Read_Data_1(rd1[0]), .Read_Data_2(rd2[0]), .Read_Valid(rv[0])
  );
  register_file_2r1w #(.N(32), .DEPTH(32), .ZERO_REG(1'b0), .BYPASS(1'b0), .REG_READ(1'b0)) u_nz (
    .clk(clk), .reset(reset), .Reg_Write(we), .Write_Register(wa), .Write_Data(wd),
    .Read_Register_1(ra1), .Read_Register_2(ra2), .Read_Enable(re),
    .Read_Data_1(rd1[1]), .Read_Data_2(rd2[1]), .Read_Valid(rv[1])
  );
  register_file_2r1w #(.N(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1), .REG_READ(1'b1)) u_rr (
    .clk(clk), .reset(reset), .Reg_Write(we), .Write_Register(wa), .Write_Data(wd),
    .Read_Register_1(ra1), .Read_Register_2(ra2), .Read_Enable(re),
    .Read_Data_1(rd1[2]), .Read_Data_2(rd2[2]), .Read_Valid(rv[2])
  );
  register_file_2r1w #(.N(32), .DEPTH(32), .ZERO_REG(1'b0), .BYPASS(1'b0), .REG_READ(1'b1)) u_rr_nb (
    .clk(clk), .reset(reset), .Reg_Write(we), .Write_Register(wa), .Write_Data(wd),
    .Read_Register_1(ra1), .Read_Register_2(ra2), .Read_Enable(re),
    .Read_Data_1(rd1[3]), .Read_Data_2(rd2[3]), .Read_Valid(rv[3])
  );
  register_file_2r1w #(.N(16), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1), .REG_READ(1'b1)) u_small (
    .clk(clk), .reset(reset), .Reg_Write(s_we), .Write_Register(s_wa), .Write_Data(s_wd),
    .Read_Register_1(s_ra1), .Read_Register_2(s_ra2), .Read_Enable(s_re),
    .Read_Data_1(s_rd1), .Read_Data_2(s_rd2), .Read_Valid(s_rv)
  );

  // Reference model state
  logic [31:0] mem_m [4][32];
  logic [31:0] rq1_m [4];
  logic [31:0] rq2_m [4];
  logic        vq_m  [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input int c, input logic [4:0] a);
    if (cfg_zero[c] && a == 5'd0) return 32'h0;
    if (cfg_byp[c] && we && wa == a) return wd;
    return mem_m[c][a];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 32; i++) mem_m[c][i] = 32'h0;
      rq1_m[c] = 32'h0;
      rq2_m[c] = 32'h0;
      vq_m[c]  = 1'b0;
    end
  endtask

  // Applies one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (cfg_rr[c]) begin
          vq_m[c] = re;
          if (re) begin
            rq1_m[c] = pick(c, ra1);
            rq2_m[c] = pick(c, ra2);
          end
        end
        if (we && !(cfg_zero[c] && wa == 5'd0)) mem_m[c][wa] = wd;
      end
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 4; c++) begin
      if (cfg_rr[c]) begin
        check($sformatf("cfg%0d_rd1", c), rd1[c], rq1_m[c]);
        check($sformatf("cfg%0d_rd2", c), rd2[c], rq2_m[c]);
        check($sformatf("cfg%0d_valid", c), {31'h0, rv[c]}, {31'h0, vq_m[c]});
      end else begin
        check($sformatf("cfg%0d_rd1", c), rd1[c], pick(c, ra1));
        check($sformatf("cfg%0d_rd2", c), rd2[c], pick(c, ra2));
        check($sformatf("cfg%0d_valid", c), {31'h0, rv[c]}, {31'h0, re});
      end
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2, input logic e);
    we  = w;
    wa  = a;
    wd  = d;
    ra1 = r1;
    ra2 = r2;
    re  = e;
  endtask

  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic [4:0] r1, input logic [4:0] r2, input logic e);
    drive(w, a, d, r1, r2, e);
    settle();
    advance();
  endtask

  task automatic small_edge_check(input string tag, input logic v, input logic [15:0] d);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, "_valid"}, {31'h0, s_rv}, {31'h0, v});
    check({tag, "_rd1"}, {16'h0, s_rd1}, {16'h0, d});
    check({tag, "_rd2"}, {16'h0, s_rd2}, {16'h0, d});
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    s_we = 1'b0; s_wa = '0; s_wd = '0; s_ra1 = '0; s_ra2 = '0; s_re = 1'b0;
    model_reset();

    // Reset state, including a write that must be discarded.
    step(1'b1, 5'd4, 32'hFFFF_FFFF, 5'd4, 5'd4, 1'b0);
    check("small_reset_valid", {31'h0, s_rv}, 32'h0);
    check("small_reset_rd1", {16'h0, s_rd1}, 32'h0);
    reset = 1'b0;

    // All registers read zero after reset.
    for (int i = 0; i < 32; i++) step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1);

    // Write then read on both ports.
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b1);
    settle();
    check("r5_port1", rd1[0], 32'hDEAD_BEEF);
    check("r5_port2", rd2[0], 32'hDEAD_BEEF);
    advance();

    // Writes to register 0.
    step(1'b1, 5'd0, 32'h1234_5678, 5'd3, 5'd3, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
    settle();
    check("r0_zero_reg", rd1[0], 32'h0);
    check("r0_no_zero_reg", rd1[1], 32'h1234_5678);
    advance();

    // Same-cycle write and read of register 9.
    drive(1'b1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9, 1'b1);
    settle();
    check("bypass_on", rd1[0], 32'hA5A5_A5A5);
    check("bypass_off_old", rd1[1], 32'h0);
    advance();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0);
    settle();
    check("bypass_off_next", rd1[1], 32'hA5A5_A5A5);
    check("rr_bypass_capture", rd1[2], 32'hA5A5_A5A5);
    check("rr_nobypass_capture", rd1[3], 32'h0);
    advance();

    // Registered-read stall sequence on the 16x8 instance.
    s_we = 1'b1; s_wa = 3'd3; s_wd = 16'h00FF; s_re = 1'b0;
    @(posedge clk); model_edge(); #1;
    s_we = 1'b0; s_ra1 = 3'd3; s_ra2 = 3'd3; s_re = 1'b1;
    small_edge_check("small_c0", 1'b1, 16'h00FF);
    s_we = 1'b1; s_wd = 16'h0F0F; s_re = 1'b0;
    small_edge_check("small_c1", 1'b0, 16'h00FF);
    s_we = 1'b0; s_re = 1'b0;
    small_edge_check("small_c2", 1'b0, 16'h00FF);
    s_re = 1'b1;
    small_edge_check("small_c3", 1'b1, 16'h0F0F);
    s_re = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] a1;
      a1 = 5'($urandom_range(31));
      step(1'($urandom_range(1)), 5'($urandom_range(31)), $urandom(), a1,
           ($urandom_range(3) == 0) ? a1 : 5'($urandom_range(31)), 1'($urandom_range(1)));
    end

    // Asynchronous reset mid-cycle.
    step(1'b1, 5'd5, 32'h1111_1111, 5'd0, 5'd0, 1'b0);
    step(1'b1, 5'd9, 32'h2222_2222, 5'd0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd9, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd9, 1'b1);
    settle();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    check("async_rst_rr_rd1", rd1[2], 32'h0);
    check("async_rst_rr_rd2", rd2[2], 32'h0);
    check("async_rst_rr_valid", {31'h0, rv[2]}, 32'h0);
    check("async_rst_comb_rd1", rd1[0], 32'h0);
    advance();
    step(1'b1, 5'd7, 32'h3333_3333, 5'd7, 5'd7, 1'b1);
    reset = 1'b0;

    // Stall right after release: registered outputs stay zero.
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd9, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd9, 1'b0);
    for (int i = 0; i < 32; i++) step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
